acc_result_fifo: RTL and testbench

// - Downstream stage of the unsigned accumulator. Captures each accumulator result (data + carry) into a

---
 rtl/acc_result_fifo.sv | 122 ++++++++++++
 tb/tb_acc_result_fifo.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/acc_result_fifo.sv
// Result FIFO behind the unsigned accumulator: first-word-fall-through queue of {carry,data}
// with saturating carry/drop statistics. Optional macro ACC_FIFO_SAT_EN stores carried results as all-ones.
module acc_result_fifo #(
    parameter int unsigned NB_DATA = 6,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned NB_CNT  = 8
) (
    input  logic                     clk,
    input  logic                     i_rst_n,
    input  logic                     i_valid,
    input  logic [NB_DATA-1:0]       i_data,
    input  logic                     i_carry,
    input  logic                     i_ready,
    output logic                     o_valid,
    output logic [NB_DATA-1:0]       o_data,
    output logic                     o_carry,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic [NB_CNT-1:0]        o_carry_cnt,
    output logic [NB_CNT-1:0]        o_drop_cnt
);

    localparam int unsigned NB_PTR = $clog2(DEPTH);
    localparam int unsigned NB_LVL = NB_PTR + 1;

    typedef struct packed {
        logic               carry;
        logic [NB_DATA-1:0] data;
    } entry_t;

    entry_t              mem_q [DEPTH];
    logic [NB_PTR-1:0]   wr_ptr_q, wr_ptr_d;
    logic [NB_PTR-1:0]   rd_ptr_q, rd_ptr_d;
    logic [NB_LVL-1:0]   level_q, level_d;
    logic [NB_CNT-1:0]   carry_cnt_q, carry_cnt_d;
    logic [NB_CNT-1:0]   drop_cnt_q, drop_cnt_d;

    logic   full_c;
    logic   empty_c;
    logic   push_c;
    logic   pop_c;
    entry_t wr_entry_c;

    // Occupancy flags come straight from the registered level.
    assign full_c  = (level_q == NB_LVL'(DEPTH));
    assign empty_c = (level_q == NB_LVL'(0));
    assign push_c  = i_valid & ~full_c;
    assign pop_c   = i_ready & ~empty_c;

    always_comb begin
        wr_entry_c.carry = i_carry;
`ifdef ACC_FIFO_SAT_EN
        wr_entry_c.data  = i_carry ? {NB_DATA{1'b1}} : i_data;
`else
        wr_entry_c.data  = i_data;
`endif
    end

    // Next-state for pointers, level and statistics.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        carry_cnt_d = carry_cnt_q;
        drop_cnt_d  = drop_cnt_q;

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + NB_PTR'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + NB_PTR'(1);
        end

        case ({push_c, pop_c})
            2'b10:   level_d = level_q + NB_LVL'(1);
            2'b01:   level_d = level_q - NB_LVL'(1);
            default: level_d = level_q;
        endcase

        if (push_c && i_carry && (carry_cnt_q != {NB_CNT{1'b1}})) begin
            carry_cnt_d = carry_cnt_q + NB_CNT'(1);
        end
        // Full is judged on the level at cycle start, so a same-cycle pop does not rescue the push.
        if (i_valid && full_c && (drop_cnt_q != {NB_CNT{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + NB_CNT'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            carry_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            carry_cnt_q <= carry_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Storage is never cleared; a push coinciding with reset is discarded.
    always_ff @(posedge clk) begin
        if (i_rst_n && push_c) begin
            mem_q[wr_ptr_q] <= wr_entry_c;
        end
    end

    assign o_valid     = ~empty_c;
    assign o_empty     = empty_c;
    assign o_full      = full_c;
    assign o_level     = level_q;
    assign o_data      = mem_q[rd_ptr_q].data;
    assign o_carry     = mem_q[rd_ptr_q].carry;
    assign o_carry_cnt = carry_cnt_q;
    assign o_drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_acc_result_fifo.sv
// Self-checking bench for acc_result_fifo: vector table plus queue scoreboard and corner sequences.
module tb_acc_result_fifo;

    localparam int unsigned NB_DATA = 6;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned NB_CNT  = 8;
    localparam int unsigned NB_LVL  = 3;
    localparam int          CNT_MAX = 255;

    logic                clk = 1'b0;
    logic                i_rst_n;
    logic                i_valid;
    logic [NB_DATA-1:0]  i_data;
    logic                i_carry;
    logic                i_ready;
    logic                o_valid;
    logic [NB_DATA-1:0]  o_data;
    logic                o_carry;
    logic                o_full;
    logic                o_empty;
    logic [NB_LVL-1:0]   o_level;
    logic [NB_CNT-1:0]   o_carry_cnt;
    logic [NB_CNT-1:0]   o_drop_cnt;

    always #5 clk = ~clk;

    acc_result_fifo #(.NB_DATA(NB_DATA), .DEPTH(DEPTH), .NB_CNT(NB_CNT)) dut (
        .clk         (clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .i_data      (i_data),
        .i_carry     (i_carry),
        .i_ready     (i_ready),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .o_carry     (o_carry),
        .o_full      (o_full),
        .o_empty     (o_empty),
        .o_level     (o_level),
        .o_carry_cnt (o_carry_cnt),
        .o_drop_cnt  (o_drop_cnt)
    );

    typedef struct {
        logic               v;
        logic [NB_DATA-1:0] d;
        logic               c;
        logic               r;
        int                 lvl;
        logic               full;
        int                 drop;
        int                 ccnt;
        logic               hvalid;
        logic [NB_DATA-1:0] hdata;
        logic               hcarry;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [NB_DATA:0] sb_q[$];
    int m_level;
    int m_carry_cnt;
    int m_drop_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [NB_DATA-1:0] exp_store(input logic [NB_DATA-1:0] d, input logic c);
`ifdef ACC_FIFO_SAT_EN
        return c ? {NB_DATA{1'b1}} : d;
`else
        if (c) return d;
        return d;
`endif
    endfunction

    // One clock: drive inputs, update the reference model, then check outputs after the edge.
    task automatic step(input logic rst_n, input logic v, input logic [NB_DATA-1:0] d,
                        input logic c, input logic r);
        logic push;
        logic pop;
        i_rst_n = rst_n;
        i_valid = v;
        i_data  = d;
        i_carry = c;
        i_ready = r;
        #1;
        if (!rst_n) begin
            sb_q.delete();
            m_level     = 0;
            m_carry_cnt = 0;
            m_drop_cnt  = 0;
        end else begin
            push = v && (m_level < int'(DEPTH));
            pop  = r && (m_level > 0);
            if (pop) begin
                check("pop_data", 32'({o_carry, o_data}), 32'(sb_q[0]));
                void'(sb_q.pop_front());
            end
            if (v && !push && m_drop_cnt < CNT_MAX) m_drop_cnt++;
            if (push) begin
                sb_q.push_back({c, exp_store(d, c)});
                if (c && m_carry_cnt < CNT_MAX) m_carry_cnt++;
            end
            m_level = m_level + int'(push) - int'(pop);
        end
        @(posedge clk);
        #1;
        check("level", 32'(o_level), 32'(m_level));
        check("full", 32'(o_full), 32'(m_level == int'(DEPTH)));
        check("empty", 32'(o_empty), 32'(m_level == 0));
        check("valid", 32'(o_valid), 32'(m_level != 0));
        check("carry_cnt", 32'(o_carry_cnt), 32'(m_carry_cnt));
        check("drop_cnt", 32'(o_drop_cnt), 32'(m_drop_cnt));
        if (m_level != 0) check("head", 32'({o_carry, o_data}), 32'(sb_q[0]));
    endtask

    vec_t tbl[16];

    initial begin
        i_rst_n = 1'b0; i_valid = 1'b0; i_data = '0; i_carry = 1'b0; i_ready = 1'b0;
        m_level = 0; m_carry_cnt = 0; m_drop_cnt = 0;

        // {v, d, c, r, level, full, drop, carry_cnt, head_valid, head_data, head_carry}
        tbl[0]  = '{1'b1, 6'd20, 1'b0, 1'b0, 1, 1'b0, 0, 0, 1'b1, 6'd20, 1'b0};
        tbl[1]  = '{1'b1, 6'd30, 1'b0, 1'b0, 2, 1'b0, 0, 0, 1'b1, 6'd20, 1'b0};
        tbl[2]  = '{1'b0, 6'd0,  1'b0, 1'b1, 1, 1'b0, 0, 0, 1'b1, 6'd30, 1'b0};
        tbl[3]  = '{1'b0, 6'd0,  1'b0, 1'b1, 0, 1'b0, 0, 0, 1'b0, 6'd0,  1'b0};
        tbl[4]  = '{1'b1, 6'd1,  1'b0, 1'b0, 1, 1'b0, 0, 0, 1'b1, 6'd1,  1'b0};
        tbl[5]  = '{1'b1, 6'd2,  1'b0, 1'b0, 2, 1'b0, 0, 0, 1'b1, 6'd1,  1'b0};
        tbl[6]  = '{1'b1, 6'd3,  1'b0, 1'b0, 3, 1'b0, 0, 0, 1'b1, 6'd1,  1'b0};
        tbl[7]  = '{1'b1, 6'd4,  1'b0, 1'b0, 4, 1'b1, 0, 0, 1'b1, 6'd1,  1'b0};
        tbl[8]  = '{1'b1, 6'd5,  1'b0, 1'b0, 4, 1'b1, 1, 0, 1'b1, 6'd1,  1'b0};
        tbl[9]  = '{1'b1, 6'd6,  1'b0, 1'b1, 3, 1'b0, 2, 0, 1'b1, 6'd2,  1'b0};
        tbl[10] = '{1'b0, 6'd0,  1'b0, 1'b1, 2, 1'b0, 2, 0, 1'b1, 6'd3,  1'b0};
        tbl[11] = '{1'b0, 6'd0,  1'b0, 1'b1, 1, 1'b0, 2, 0, 1'b1, 6'd4,  1'b0};
        tbl[12] = '{1'b0, 6'd0,  1'b0, 1'b1, 0, 1'b0, 2, 0, 1'b0, 6'd0,  1'b0};
        tbl[13] = '{1'b1, 6'd10, 1'b1, 1'b0, 1, 1'b0, 2, 1, 1'b1, exp_store(6'd10, 1'b1), 1'b1};
        tbl[14] = '{1'b0, 6'd0,  1'b0, 1'b1, 0, 1'b0, 2, 1, 1'b0, 6'd0,  1'b0};
        tbl[15] = '{1'b0, 6'd0,  1'b0, 1'b1, 0, 1'b0, 2, 1, 1'b0, 6'd0,  1'b0};

        // Reset, then idle
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        check("idle_empty", 32'(o_empty), 32'd1);
        check("idle_level", 32'(o_level), 32'd0);

        for (int i = 0; i < 16; i++) begin
            step(1'b1, tbl[i].v, tbl[i].d, tbl[i].c, tbl[i].r);
            check($sformatf("tbl%0d_level", i), 32'(o_level), 32'(tbl[i].lvl));
            check($sformatf("tbl%0d_full", i), 32'(o_full), 32'(tbl[i].full));
            check($sformatf("tbl%0d_empty", i), 32'(o_empty), 32'(tbl[i].lvl == 0));
            check($sformatf("tbl%0d_drop", i), 32'(o_drop_cnt), 32'(tbl[i].drop));
            check($sformatf("tbl%0d_ccnt", i), 32'(o_carry_cnt), 32'(tbl[i].ccnt));
            check($sformatf("tbl%0d_valid", i), 32'(o_valid), 32'(tbl[i].hvalid));
            if (tbl[i].hvalid) begin
                check($sformatf("tbl%0d_hdata", i), 32'(o_data), 32'(tbl[i].hdata));
                check($sformatf("tbl%0d_hcarry", i), 32'(o_carry), 32'(tbl[i].hcarry));
            end
        end

        // Reset mid-operation with a concurrent push
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 6'(7 + i), 1'(i), 1'b0);
        step(1'b0, 1'b1, 6'd50, 1'b1, 1'b1);
        check("rst_level", 32'(o_level), 32'd0);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_ccnt", 32'(o_carry_cnt), 32'd0);
        check("rst_drop", 32'(o_drop_cnt), 32'd0);

        // Streaming push/pop pairs across pointer wrap
        step(1'b1, 1'b1, 6'd40, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 6'(41 + i), 1'(i % 2), 1'b1);
        step(1'b1, 1'b0, '0, 1'b0, 1'b1);
        check("stream_empty", 32'(o_empty), 32'd1);

        // Drop counter saturation
        for (int i = 0; i < 264; i++) step(1'b1, 1'b1, 6'(i), 1'b0, 1'b0);
        check("drop_sat", 32'(o_drop_cnt), 32'(CNT_MAX));
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, 1'b0, 1'b1);

        // Carry counter saturation
        step(1'b1, 1'b1, 6'd1, 1'b1, 1'b0);
        for (int i = 0; i < 260; i++) step(1'b1, 1'b1, 6'(i), 1'b1, 1'b1);
        check("carry_sat", 32'(o_carry_cnt), 32'(CNT_MAX));
        step(1'b1, 1'b0, '0, 1'b0, 1'b1);
        check("final_empty", 32'(o_empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
